// File: rtl/cam_pkg.sv
// Shared types and default geometry for the CAM search engine.
// The search FSM state encoding lives here so the bench and any wrappers agree on it.
package cam_pkg;

  localparam int CAM_DATA_WIDTH = 4;
  localparam int CAM_ADDR_WIDTH = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } cam_state_t;

endpackage

// File: rtl/cam_storage.sv
// CAM table storage: entry data array plus per-entry valid bits.
// One synchronous write port and one combinational indexed read port.
module cam_storage #(
  parameter int DATA_WIDTH = 4,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  Clk,
  input  logic                  Rest,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0]      valid;

  // Data is left unreset on purpose; the valid bits alone define table contents.
  always_ff @(posedge Clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge Clk or negedge Rest) begin
    if (!Rest) begin
      valid <= '0;
    end else if (wr_en) begin
      valid[wr_addr] <= 1'b1;
    end
  end

  assign rd_data  = mem[rd_addr];
  assign rd_valid = valid[rd_addr];

endmodule

// File: rtl/cam_search_engine.sv
// Sequential CAM search: scans every entry once per search and reports the lowest match.
// Optional macro CAM_MATCH_COUNT_EN adds the Match_Count output and its hit counter.
//
// state  | meaning
// IDLE   | accepts writes and search strobes
// SEARCH | compares one entry per cycle, index 0 .. DEPTH-1
// DONE   | one-cycle Done pulse, results already visible
module cam_search_engine
  import cam_pkg::*;
#(
  parameter int DATA_WIDTH = CAM_DATA_WIDTH,
  parameter int ADDR_WIDTH = CAM_ADDR_WIDTH
) (
  input  logic                  Clk,
  input  logic                  Rest,
  input  logic                  Writ_Enable,
  input  logic [DATA_WIDTH-1:0] Data_IN,
  input  logic [ADDR_WIDTH-1:0] WR_Addr,
  input  logic                  CMP_Start,
  input  logic [DATA_WIDTH-1:0] CMP_Din,
  output logic                  Busy,
  output logic                  Done,
  output logic                  Match,
  output logic [ADDR_WIDTH-1:0] Match_Addr
`ifdef CAM_MATCH_COUNT_EN
  ,
  output logic [ADDR_WIDTH:0]   Match_Count
`endif
);

  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'((2 ** ADDR_WIDTH) - 1);

  cam_state_t state, state_next;

  logic [DATA_WIDTH-1:0] key;
  logic [ADDR_WIDTH-1:0] index;
  logic                  hit;
  logic [ADDR_WIDTH-1:0] hit_addr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  entry_hit;
  logic                  wr_accept;
  logic                  start_accept;
  logic                  last_cmp;

  assign wr_accept    = Writ_Enable && (state == IDLE);
  assign start_accept = CMP_Start && (state == IDLE);
  assign last_cmp     = (state == SEARCH) && (index == LAST_IDX);
  assign entry_hit    = rd_valid && (rd_data == key);

  cam_storage #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_storage (
    .Clk      (Clk),
    .Rest     (Rest),
    .wr_en    (wr_accept),
    .wr_addr  (WR_Addr),
    .wr_data  (Data_IN),
    .rd_addr  (index),
    .rd_data  (rd_data),
    .rd_valid (rd_valid)
  );

  always_ff @(posedge Clk or negedge Rest) begin
    if (!Rest) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    Busy       = 1'b0;
    Done       = 1'b0;
    case (state)
      IDLE: begin
        if (CMP_Start) begin
          state_next = SEARCH;
        end
      end
      SEARCH: begin
        Busy = 1'b1;
        if (index == LAST_IDX) begin
          state_next = DONE;
        end
      end
      DONE: begin
        Done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Results load on the final compare so they are already valid while Done is high.
  always_ff @(posedge Clk or negedge Rest) begin
    if (!Rest) begin
      key        <= '0;
      index      <= '0;
      hit        <= 1'b0;
      hit_addr   <= '0;
      Match      <= 1'b0;
      Match_Addr <= '0;
    end else if (start_accept) begin
      key      <= CMP_Din;
      index    <= '0;
      hit      <= 1'b0;
      hit_addr <= '0;
    end else if (state == SEARCH) begin
      index <= index + ADDR_WIDTH'(1);
      if (entry_hit && !hit) begin
        hit_addr <= index;
      end
      hit <= hit | entry_hit;
      if (last_cmp) begin
        Match <= hit | entry_hit;
        if (hit) begin
          Match_Addr <= hit_addr;
        end else if (entry_hit) begin
          Match_Addr <= index;
        end else begin
          Match_Addr <= '0;
        end
      end
    end
  end

`ifdef CAM_MATCH_COUNT_EN
  logic [CW-1:0] hit_count;

  always_ff @(posedge Clk or negedge Rest) begin
    if (!Rest) begin
      hit_count   <= '0;
      Match_Count <= '0;
    end else if (start_accept) begin
      hit_count <= '0;
    end else if (state == SEARCH) begin
      hit_count <= hit_count + CW'(entry_hit);
      if (last_cmp) begin
        Match_Count <= hit_count + CW'(entry_hit);
      end
    end
  end
`else
  // Without the counter, Match and Match_Addr alone report the search result.
`endif

endmodule

// File: tb/tb_cam_search_engine.sv
// Self-checking bench for cam_search_engine: directed scenarios then randomized traffic
// against a simple array model of the table. Honors CAM_MATCH_COUNT_EN when defined.
module tb_cam_search_engine;

  localparam int DW    = 4;
  localparam int AW    = 2;
  localparam int DEPTH = 4;

  logic          Clk = 1'b0;
  logic          Rest;
  logic          Writ_Enable;
  logic [DW-1:0] Data_IN;
  logic [AW-1:0] WR_Addr;
  logic          CMP_Start;
  logic [DW-1:0] CMP_Din;
  logic          Busy;
  logic          Done;
  logic          Match;
  logic [AW-1:0] Match_Addr;
`ifdef CAM_MATCH_COUNT_EN
  logic [AW:0]   Match_Count;
`endif

  int tests = 0;
  int fails = 0;

  logic [DW-1:0] m_data  [DEPTH];
  bit            m_valid [DEPTH];
  logic [DW-1:0] inj_data;
  logic [AW-1:0] inj_addr;

  cam_search_engine #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .Clk         (Clk),
    .Rest        (Rest),
    .Writ_Enable (Writ_Enable),
    .Data_IN     (Data_IN),
    .WR_Addr     (WR_Addr),
    .CMP_Start   (CMP_Start),
    .CMP_Din     (CMP_Din),
    .Busy        (Busy),
    .Done        (Done),
    .Match       (Match),
    .Match_Addr  (Match_Addr)
`ifdef CAM_MATCH_COUNT_EN
    ,
    .Match_Count (Match_Count)
`endif
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    Writ_Enable = 1'b1;
    WR_Addr     = a;
    Data_IN     = d;
    tick();
    Writ_Enable = 1'b0;
    m_data[a]   = d;
    m_valid[a]  = 1'b1;
  endtask

  // inj: cycle after the strobe (1..DEPTH+1) in which a write and strobe are attempted; 0 = none
  task automatic do_search(input logic [DW-1:0] key, input bit wr, input logic [AW-1:0] wa,
                           input logic [DW-1:0] wd, input int inj);
    bit            e_match;
    logic [AW-1:0] e_addr;
    int            e_count;
    if (wr) begin
      m_data[wa]  = wd;
      m_valid[wa] = 1'b1;
    end
    e_match = 1'b0;
    e_addr  = '0;
    e_count = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (m_valid[i] && m_data[i] == key) begin
        if (!e_match) e_addr = AW'(i);
        e_match = 1'b1;
        e_count++;
      end
    end
    Writ_Enable = wr;
    WR_Addr     = wa;
    Data_IN     = wd;
    CMP_Start   = 1'b1;
    CMP_Din     = key;
    tick();
    Writ_Enable = 1'b0;
    CMP_Start   = 1'b0;
    for (int c = 1; c <= DEPTH; c++) begin
      if (c == inj) begin
        Writ_Enable = 1'b1;
        WR_Addr     = inj_addr;
        Data_IN     = inj_data;
        CMP_Start   = 1'b1;
        CMP_Din     = inj_data;
      end
      check($sformatf("busy_c%0d", c), Busy, 1);
      check($sformatf("done_early_c%0d", c), Done, 0);
      tick();
      Writ_Enable = 1'b0;
      CMP_Start   = 1'b0;
    end
    if (inj == DEPTH + 1) begin
      Writ_Enable = 1'b1;
      WR_Addr     = inj_addr;
      Data_IN     = inj_data;
      CMP_Start   = 1'b1;
      CMP_Din     = inj_data;
    end
    check("done_pulse", Done, 1);
    check("busy_at_done", Busy, 0);
    check($sformatf("match_key%0h", key), Match, e_match);
    check($sformatf("match_addr_key%0h", key), Match_Addr, e_addr);
`ifdef CAM_MATCH_COUNT_EN
    check($sformatf("match_count_key%0h", key), Match_Count, e_count);
`endif
    tick();
    Writ_Enable = 1'b0;
    CMP_Start   = 1'b0;
    check("done_one_cycle", Done, 0);
    check("idle_after_done", Busy, 0);
    check("match_hold", Match, e_match);
    check("match_addr_hold", Match_Addr, e_addr);
  endtask

  initial begin
    Rest        = 1'b0;
    Writ_Enable = 1'b0;
    Data_IN     = '0;
    WR_Addr     = '0;
    CMP_Start   = 1'b0;
    CMP_Din     = '0;
    inj_data    = '0;
    inj_addr    = '0;
    model_clear();
    #12;
    check("rst_busy", Busy, 0);
    check("rst_done", Done, 0);
    check("rst_match", Match, 0);
    check("rst_match_addr", Match_Addr, 0);
`ifdef CAM_MATCH_COUNT_EN
    check("rst_match_count", Match_Count, 0);
`endif
    tick();
    Rest = 1'b1;
    tick();

    // empty table: zero key must not match unwritten entries
    do_search(4'h0, 1'b0, '0, '0, 0);

    do_write(2'd2, 4'hA);
    do_search(4'hA, 1'b0, '0, '0, 0);

    do_write(2'd1, 4'h9);
    do_write(2'd3, 4'h9);
    do_search(4'h9, 1'b0, '0, '0, 0);

    // write and strobe while busy are dropped
    inj_data = 4'h5;
    inj_addr = 2'd0;
    do_search(4'hA, 1'b0, '0, '0, 2);
    do_search(4'h5, 1'b0, '0, '0, 0);
    check("dropped_write_no_match", Match, 0);

    // same-cycle write and search sees the new entry
    do_search(4'h7, 1'b1, 2'd3, 4'h7, 0);
    check("same_cycle_addr", Match_Addr, 3);

    // reset in search cycle 2 aborts with no Done
    CMP_Start = 1'b1;
    CMP_Din   = 4'hA;
    tick();
    CMP_Start = 1'b0;
    tick();
    Rest = 1'b0;
    #1;
    check("abort_busy", Busy, 0);
    check("abort_done", Done, 0);
    check("abort_match", Match, 0);
    tick();
    Rest = 1'b1;
    model_clear();
    for (int i = 0; i < DEPTH + 2; i++) begin
      check($sformatf("abort_no_done_%0d", i), Done, 0);
      tick();
    end
    do_search(4'hA, 1'b0, '0, '0, 0);
    check("abort_cleared_valid", Match, 0);

    for (int n = 0; n < 60; n++) begin
      logic [DW-1:0] k;
      int            pick;
      pick = $urandom_range(0, DEPTH - 1);
      if (m_valid[pick] && $urandom_range(0, 1) == 1) k = m_data[pick];
      else k = DW'($urandom_range(0, 15));
      case ($urandom_range(0, 3))
        0, 1: do_write(AW'($urandom_range(0, DEPTH - 1)), DW'($urandom_range(0, 7)));
        2: begin
          inj_data = DW'($urandom_range(0, 15));
          inj_addr = AW'($urandom_range(0, DEPTH - 1));
          do_search(k, 1'b0, '0, '0, $urandom_range(0, DEPTH + 1));
        end
        default: do_search(k, 1'b1, AW'($urandom_range(0, DEPTH - 1)),
                           DW'($urandom_range(0, 7)), 0);
      endcase
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cam_search_engine.md
CAM_SEARCH_ENGINE -- requirements
Module: cam_search_engine

Interface
REQ-001 Parameter DATA_WIDTH, default 4, SHALL set the entry and key width in bits.
REQ-002 Parameter ADDR_WIDTH, default 2, SHALL set the address width; DEPTH = 2**ADDR_WIDTH entries.
REQ-003 Clk  input  1  SHALL be the single clock; all state SHALL change on its rising edge.
REQ-004 Rest  input  1  SHALL be the reset: asynchronous, active-low.
REQ-005 Writ_Enable  input  1  SHALL request a write of Data_IN to WR_Addr.
REQ-006 Data_IN  input  DATA_WIDTH  SHALL carry the write data.
REQ-007 WR_Addr  input  ADDR_WIDTH  SHALL carry the write address.
REQ-008 CMP_Start  input  1  SHALL request a search; it is a single-cycle strobe.
REQ-009 CMP_Din  input  DATA_WIDTH  SHALL carry the search key, sampled when CMP_Start is accepted.
REQ-010 Busy  output  1  SHALL be high while a search is in progress.
REQ-011 Done  output  1  SHALL be a one-cycle pulse marking search completion.
REQ-012 Match  output  1  SHALL flag that at least one valid entry equals the key.
REQ-013 Match_Addr  output  ADDR_WIDTH  SHALL give the lowest matching address.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, SEARCH and DONE.
REQ-015 IDLE with CMP_Start=1: latch CMP_Din as key, clear index, clear the hit flag, go to SEARCH.
REQ-016 SEARCH: each cycle compare entry[index] with the key, count a hit only if that entry is valid, and increment index; after index DEPTH-1, go to DONE.
REQ-017 DONE: pulse Done for one cycle, update Match and Match_Addr, return to IDLE.
REQ-018 Latency: for a strobe at edge T, Busy SHALL be 1 for cycles T+1..T+DEPTH and Done SHALL be 1 in cycle T+DEPTH+1; the full table SHALL always be scanned, with no early exit.
REQ-019 Match_Addr SHALL be the lowest matching index; with no match, Match=0 and Match_Addr=0.
REQ-020 Match and Match_Addr SHALL hold their values until the next DONE.
REQ-021 A write SHALL take effect in one cycle, storing Data_IN and setting valid[WR_Addr], but only when the state is IDLE.
REQ-022 Writ_Enable while the state is SEARCH or DONE SHALL be ignored without side effect.
REQ-023 CMP_Start while the state is SEARCH or DONE SHALL be ignored.
REQ-024 Writ_Enable and CMP_Start in the same IDLE cycle: the write SHALL complete first, and the search SHALL see the new entry.
REQ-025 Never-written entries SHALL never match, even when the key equals the stored zeroes.

Reset
REQ-026 Rest=0 SHALL asynchronously force: state IDLE, all valid bits 0, key 0, index 0, Busy=0, Done=0, Match=0, Match_Addr=0.
REQ-027 Reset during SEARCH SHALL abort the search with no Done pulse; Busy SHALL return to 0 immediately.
REQ-028 Entry data need not be reset; only the valid bits define table contents.

Configuration
REQ-029 With macro CAM_MATCH_COUNT_EN defined, output Match_Count (ADDR_WIDTH+1 bits) SHALL give the number of valid matching entries; it SHALL update at DONE, be 0 at reset and hold until the next DONE.
REQ-030 Without CAM_MATCH_COUNT_EN, the Match_Count port and its counter SHALL NOT exist; all other behaviour SHALL be identical.

Structure
REQ-031 Package cam_pkg SHALL hold the FSM state enum (IDLE/SEARCH/DONE) and the default DATA_WIDTH/ADDR_WIDTH constants.
REQ-032 Sub-module cam_storage SHALL hold the data array and valid bits: one write port and one indexed read port.
REQ-033 The FSM, key register and result registers SHALL reside in cam_search_engine.

Verification (DATA_WIDTH=4, ADDR_WIDTH=2)
REQ-034 Reset, then search key 4'h0 -> Busy high for 4 cycles, Done at T+5, Match=0, Match_Addr=0.
REQ-035 Write A at addr 2, then search A -> Match=1, Match_Addr=2; with CAM_MATCH_COUNT_EN defined, Match_Count=1.
REQ-036 Write 9 at addrs 1 and 3, then search 9 -> Match_Addr=1; with CAM_MATCH_COUNT_EN defined, Match_Count=2.
REQ-037 During Busy, write 5 at addr 0 and strobe CMP_Start -> write dropped and second search ignored; a later search for 5 returns Match=0.
REQ-038 Same-cycle write 7 at addr 3 plus search 7 from IDLE -> Match=1, Match_Addr=3.
REQ-039 Assert Rest=0 at search cycle 2 -> Busy=0 at once, no Done pulse, and a later search for previously written data returns Match=0.
